// File: rtl/mod_addsub_pipe.sv
// Multi-lane modular add/subtract with a 2-stage pipeline and one shared modulus per beat.
// Stage 1 forms the raw BITWIDTH+1 sum/difference; stage 2 applies one conditional correction by Q.
module mod_addsub_pipe #(
    parameter int BITWIDTH = 32,
    parameter int LANES    = 4
) (
    input  logic                      iClk,
    input  logic                      iRstN,
    input  logic                      iEn,
    input  logic                      iClr,
    input  logic                      iValid,
    output logic                      oReady,
    input  logic                      iSub,
    input  logic [LANES*BITWIDTH-1:0] iData0,
    input  logic [LANES*BITWIDTH-1:0] iData1,
    input  logic [BITWIDTH-1:0]       iQ,
    output logic                      oValid,
    input  logic                      iReady,
    output logic [LANES*BITWIDTH-1:0] oData
);
    localparam int W = BITWIDTH + 1;

    // Handshake: a beat transfers on any edge where valid && ready are both high;
    // valid never depends on ready, and ready drops only when the output slot is stalled.
    logic                      stall;
    logic                      s1Valid;
    logic                      s1Sub;
    logic [BITWIDTH-1:0]       s1Q;
    logic [LANES*W-1:0]        s1Raw;
    logic                      s2Valid;
    logic [LANES*BITWIDTH-1:0] s2Data;
    logic [LANES*W-1:0]        rawNext;
    logic [LANES*BITWIDTH-1:0] corrNext;

    assign stall  = s2Valid && !iReady;
    assign oReady = iRstN && iEn && !stall;
    assign oValid = s2Valid;
    assign oData  = s2Data;

    for (genvar k = 0; k < LANES; k++) begin : gLane
        logic [W-1:0] opA;
        logic [W-1:0] opB;
        logic [W-1:0] raw;
        logic [W-1:0] qExt;
        logic [W-1:0] fixed;

        assign opA  = {1'b0, iData0[k*BITWIDTH +: BITWIDTH]};
        assign opB  = {1'b0, iData1[k*BITWIDTH +: BITWIDTH]};
        assign rawNext[k*W +: W] = iSub ? (opA - opB) : (opA + opB);

        // The MSB of a difference is the borrow; for a sum it is the carry out.
        assign raw   = s1Raw[k*W +: W];
        assign qExt  = {1'b0, s1Q};
        assign fixed = s1Sub ? (raw[W-1] ? raw + qExt : raw)
                             : ((raw >= qExt) ? raw - qExt : raw);
        assign corrNext[k*BITWIDTH +: BITWIDTH] = fixed[BITWIDTH-1:0];
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            s1Valid <= 1'b0;
            s1Sub   <= 1'b0;
            s1Q     <= '0;
            s1Raw   <= '0;
            s2Valid <= 1'b0;
            s2Data  <= '0;
        end else if (iEn) begin
            if (iClr) begin
                s1Valid <= 1'b0;
                s2Valid <= 1'b0;
            end else if (!stall) begin
                // Not stalled means stage 2 empties or is consumed, so both stages shift together.
                s1Valid <= iValid;
                s2Valid <= s1Valid;
                if (iValid) begin
                    s1Raw <= rawNext;
                    s1Q   <= iQ;
                    s1Sub <= iSub;
                end
                if (s1Valid) begin
                    s2Data <= corrNext;
                end
            end
        end
    end
endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed-vector bench for mod_addsub_pipe: table of hand-computed beats, stall/clear/reset
// sequences, then constrained random traffic checked against an arithmetic reference.
module tb_mod_addsub_pipe;
    localparam int BW = 32;
    localparam int LN = 4;
    localparam int DW = BW * LN;

    logic          iClk;
    logic          iRstN;
    logic          iEn;
    logic          iClr;
    logic          iValid;
    logic          oReady;
    logic          iSub;
    logic [DW-1:0] iData0;
    logic [DW-1:0] iData1;
    logic [BW-1:0] iQ;
    logic          oValid;
    logic          iReady;
    logic [DW-1:0] oData;

    mod_addsub_pipe #(.BITWIDTH(BW), .LANES(LN)) dut (
        .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iValid(iValid),
        .oReady(oReady), .iSub(iSub), .iData0(iData0), .iData1(iData1), .iQ(iQ),
        .oValid(oValid), .iReady(iReady), .oData(oData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic          sub;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [BW-1:0] q;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          tbl[16];
    logic [DW-1:0] exp_q[$];
    int            acc_q[$];
    int            cyc = 0;
    int            chk_cnt = 0;
    int            pass_cnt = 0;
    bit            chk_lat = 1'b0;
    logic [DW-1:0] held;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [DW-1:0] rep(input logic [BW-1:0] x);
        return {LN{x}};
    endfunction

    function automatic logic [DW-1:0] model(input logic sub, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [BW-1:0] q);
        logic [DW-1:0] r;
        longint x, y, m;
        r = '0;
        m = longint'(q);
        for (int k = 0; k < LN; k++) begin
            x = longint'(a[k*BW +: BW]);
            y = longint'(b[k*BW +: BW]);
            r[k*BW +: BW] = sub ? BW'((x - y + m) % m) : BW'((x + y) % m);
        end
        return r;
    endfunction

    // Output monitor: every consumed beat must match the head of the expected queue.
    always @(posedge iClk) begin
        if (iRstN && iEn && oValid && iReady) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL spurious_output: got %h expected no beat", oData);
            end else begin
                check("out_data", oData, exp_q.pop_front());
                if (chk_lat) check("latency", DW'(cyc + 1 - acc_q.pop_front()), DW'(2));
                else void'(acc_q.pop_front());
            end
        end
        cyc <= cyc + 1;
    end

    task automatic send_beat(input logic sub, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [BW-1:0] q, input logic [DW-1:0] exp);
        int n = 0;
        @(negedge iClk);
        iValid = 1'b1; iSub = sub; iData0 = a; iData1 = b; iQ = q;
        #1;
        while (!oReady && n < 50) begin
            @(negedge iClk); #1; n++;
        end
        if (!oReady) begin
            chk_cnt++;
            $display("FAIL accept_timeout: got oReady=0 expected 1");
        end else begin
            exp_q.push_back(exp);
            acc_q.push_back(cyc + 1);
        end
        @(posedge iClk); #1;
        iValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        iValid = 1'b0; iReady = 1'b1; iEn = 1'b1; iClr = 1'b0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge iClk); n++;
        end
        check("drain_remaining", DW'(exp_q.size()), DW'(0));
        exp_q.delete();
        acc_q.delete();
    endtask

    initial begin
        logic [DW-1:0] ra, rb;
        logic [BW-1:0] rq;
        logic          rs;
        int            idx;

        iRstN = 1'b0; iEn = 1'b1; iClr = 1'b0; iValid = 1'b0; iReady = 1'b1;
        iSub = 1'b0; iData0 = '0; iData1 = '0; iQ = 32'd1;

        // Q sweep 23..32 on A=10, B=20 (sum 30), then subtract and wide-operand cases.
        for (int i = 0; i < 10; i++) tbl[i] = '{1'b0, rep(10), rep(20), BW'(23 + i), '0};
        tbl[0].exp = rep(7);  tbl[1].exp = rep(6);  tbl[2].exp = rep(5);  tbl[3].exp = rep(4);
        tbl[4].exp = rep(3);  tbl[5].exp = rep(2);  tbl[6].exp = rep(1);  tbl[7].exp = rep(0);
        tbl[8].exp = rep(30); tbl[9].exp = rep(30);
        tbl[10] = '{1'b1, rep(10), rep(20), 32'd23, rep(13)};
        tbl[11] = '{1'b1, rep(20), rep(10), 32'd23, rep(10)};
        tbl[12] = '{1'b1, rep(0),  rep(0),  32'd23, rep(0)};
        tbl[13] = '{1'b0, rep(32'hFFFFFFFE), rep(32'hFFFFFFFE), 32'hFFFFFFFF, rep(32'hFFFFFFFD)};
        tbl[14] = '{1'b0, {32'd0, 32'd3, 32'd500, 32'd999}, {32'd999, 32'd4, 32'd600, 32'd1},
                    32'd1000, {32'd999, 32'd7, 32'd100, 32'd0}};
        tbl[15] = '{1'b1, {32'd1, 32'hFFFFFFFE, 32'd5, 32'd0},
                    {32'hFFFFFFFE, 32'hFFFFFFFE, 32'd3, 32'd1}, 32'hFFFFFFFF,
                    {32'd2, 32'd0, 32'd2, 32'hFFFFFFFE}};

        #1;
        check("reset_ovalid", DW'(oValid), DW'(0));
        check("reset_odata", oData, '0);
        check("reset_oready", DW'(oReady), DW'(0));
        @(negedge iClk); iRstN = 1'b1;
        #1;
        check("post_reset_oready", DW'(oReady), DW'(1));

        // Back-to-back table vectors with a 2-cycle latency check on each.
        chk_lat = 1'b1;
        for (int i = 0; i < 16; i++) send_beat(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].exp);
        drain();

        // Out-of-range operands receive a single correction step only.
        chk_lat = 1'b0;
        send_beat(1'b0, rep(32'hFFFFFFFF), rep(32'hFFFFFFFF), 32'd5, rep(32'hFFFFFFF9));
        drain();

        // 8-beat stream with iReady low for three cycles mid-stream.
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            @(negedge iClk);
            iReady = !(c >= 3 && c <= 5);
            iValid = 1'b1; iSub = 1'b0; iQ = 32'd100;
            iData0 = rep(BW'(idx * 7)); iData1 = rep(BW'(idx * 3 + 1));
            #1;
            if (c == 3) begin
                held = oData;
                check("stall_oready", DW'(oReady), DW'(0));
            end
            if (c == 4 || c == 5) begin
                check("hold_ovalid", DW'(oValid), DW'(1));
                check("hold_odata", oData, held);
                check("hold_oready", DW'(oReady), DW'(0));
            end
            if (oReady) begin
                exp_q.push_back(rep(BW'((idx * 10 + 1) % 100)));
                acc_q.push_back(cyc + 1);
                idx++;
            end
        end
        @(posedge iClk); #1;
        iValid = 1'b0;
        drain();

        // Clear with two beats in flight, output held back by iReady=0.
        iReady = 1'b0;
        send_beat(1'b0, rep(1), rep(2), 32'd50, rep(3));
        send_beat(1'b0, rep(4), rep(5), 32'd50, rep(9));
        @(negedge iClk);
        check("pre_clear_ovalid", DW'(oValid), DW'(1));
        iClr = 1'b1;
        @(posedge iClk); #1;
        iClr = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge iClk);
        check("clear_ovalid", DW'(oValid), DW'(0));
        iReady = 1'b1;
        send_beat(1'b1, rep(3), rep(8), 32'd11, rep(6));
        drain();

        // Clear while disabled must not drop the held beat.
        iReady = 1'b0;
        send_beat(1'b0, rep(40), rep(30), 32'd60, rep(10));
        @(negedge iClk); iEn = 1'b0; iClr = 1'b1;
        #1;
        check("disabled_oready", DW'(oReady), DW'(0));
        @(negedge iClk); iEn = 1'b1; iClr = 1'b0;
        drain();

        // Asynchronous reset mid-stream, then first beat latency.
        send_beat(1'b0, rep(2), rep(2), 32'd9, rep(4));
        send_beat(1'b0, rep(3), rep(3), 32'd9, rep(6));
        @(negedge iClk); #2;
        iRstN = 1'b0;
        #1;
        check("midrst_ovalid", DW'(oValid), DW'(0));
        check("midrst_odata", oData, '0);
        check("midrst_oready", DW'(oReady), DW'(0));
        exp_q.delete();
        acc_q.delete();
        @(negedge iClk); iRstN = 1'b1;
        chk_lat = 1'b1;
        send_beat(1'b1, rep(0), rep(1), 32'd7, rep(6));
        drain();
        chk_lat = 1'b0;

        // Constrained random traffic within the A<Q, B<Q precondition.
        for (int c = 0; c < 400; c++) begin
            @(negedge iClk);
            iEn    = ($urandom_range(9, 0) != 0);
            iReady = iEn && ($urandom_range(3, 0) != 0);
            iValid = $urandom_range(1, 0) == 1;
            rq = $urandom_range(32'hFFFFFFFF, 1);
            rs = $urandom_range(1, 0) == 1;
            for (int k = 0; k < LN; k++) begin
                ra[k*BW +: BW] = $urandom % rq;
                rb[k*BW +: BW] = $urandom % rq;
            end
            iSub = rs; iQ = rq; iData0 = ra; iData1 = rb;
            #1;
            if (iValid && oReady) begin
                exp_q.push_back(model(rs, ra, rb, rq));
                acc_q.push_back(cyc + 1);
            end
        end
        @(posedge iClk); #1;
        iValid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
